// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold and starvation timeout.
// The owner keeps the grant while requesting, up to MAX_HOLD cycles while others wait.
module rr_hold_arbiter #(
    parameter  int N        = 3,
    parameter  int MAX_HOLD = 8,
    localparam int ID_W     = $clog2(N)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N-1:0]    r,
    output logic [N-1:0]    g,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id,
    output logic            preempt
);
    localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HC_MAX = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [HC_W-1:0] hold_cnt;

    // First requester at or after s (cyclic), optionally skipping x.
    function automatic logic [ID_W-1:0] pick(input logic [N-1:0] req,
                                             input logic [ID_W-1:0] s,
                                             input logic use_x,
                                             input logic [ID_W-1:0] x);
        logic [ID_W-1:0] res;
        int idx;
        res = '0;
        for (int o = N - 1; o >= 0; o--) begin
            idx = (int'(s) + o) % N;
            if (req[idx] && !(use_x && idx == int'(x)))
                res = ID_W'(idx);
        end
        return res;
    endfunction

    logic [ID_W-1:0] k_nxt;
    logic [N-1:0]    others;
    logic [ID_W-1:0] p_idle;
    logic [ID_W-1:0] p_hand;

    always_comb begin
        k_nxt  = (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + 1'b1;
        others = r & ~(N'(1) << gnt_id);
        p_idle = pick(r, ptr, 1'b0, '0);
        p_hand = pick(r, k_nxt, 1'b1, gnt_id);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            g         <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            preempt   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (|r) begin
                        state     <= GRANT;
                        g         <= N'(1) << p_idle;
                        gnt_valid <= 1'b1;
                        gnt_id    <= p_idle;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (!r[gnt_id]) begin
                        ptr <= k_nxt;
                        if (|others) begin
                            g        <= N'(1) << p_hand;
                            gnt_id   <= p_hand;
                            hold_cnt <= '0;
                        end else begin
                            state     <= IDLE;
                            g         <= '0;
                            gnt_valid <= 1'b0;
                            gnt_id    <= '0;
                            hold_cnt  <= '0;
                        end
                    end else if (MAX_HOLD > 0 && hold_cnt == HC_MAX && |others) begin
                        g        <= N'(1) << p_hand;
                        gnt_id   <= p_hand;
                        ptr      <= k_nxt;
                        hold_cnt <= '0;
                        preempt  <= 1'b1;
                    end else if (MAX_HOLD > 0 && hold_cnt != HC_MAX) begin
                        // Saturate so a lone owner is cut off as soon as a rival shows up.
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter (N=3, MAX_HOLD=4): cycle model feeds a scoreboard queue,
// plus directed checks on the key scenarios.
module tb_rr_hold_arbiter;
    localparam int N  = 3;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [N-1:0] r = '0;
    logic [N-1:0] g;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         preempt;

    rr_hold_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .resetn(resetn), .r(r), .g(g),
        .gnt_valid(gnt_valid), .gnt_id(gnt_id), .preempt(preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] g;
        logic         pre;
        logic [1:0]   id;
        logic         vld;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // reference state: owner index (-1 = idle), next search point, cycles held so far
    int m_own = -1;
    int m_ptr = 0;
    int m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mpick(input logic [N-1:0] rv, input int s, input int x);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (s + k) % N;
            if (rv[i] && i != x) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [N-1:0] rv, input logic rn, output exp_t e);
        int nx;
        e.pre = 1'b0;
        if (!rn) begin
            m_own = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_own < 0) begin
            if (rv != 0) begin
                m_own = mpick(rv, m_ptr, -1);
                m_cnt = 1;
            end
        end else if (!rv[m_own]) begin
            m_ptr = (m_own + 1) % N;
            m_own = mpick(rv, m_ptr, m_own);
            m_cnt = 1;
        end else begin
            nx = mpick(rv, (m_own + 1) % N, m_own);
            if (m_cnt >= MH && nx >= 0) begin
                m_ptr = (m_own + 1) % N;
                m_own = nx;
                m_cnt = 1;
                e.pre = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        e.vld = (m_own >= 0);
        e.g   = (m_own >= 0) ? N'(1) << m_own : '0;
        e.id  = (m_own >= 0) ? 2'(m_own) : 2'd0;
    endtask

    task automatic step(input logic [N-1:0] rv, input logic rn);
        exp_t e;
        @(negedge clk);
        r = rv;
        resetn = rn;
        model_edge(rv, rn, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("g", 32'(g), 32'(e.g));
        chk("preempt", 32'(preempt), 32'(e.pre));
        chk("gnt_id", 32'(gnt_id), 32'(e.id));
        chk("gnt_valid", 32'(gnt_valid), 32'(e.vld));
        chk("onehot0", 32'($onehot0(g)), 32'd1);
    endtask

    initial begin
        // 1: reset held with all requesting
        for (int i = 0; i < 5; i++) step(3'b111, 1'b0);
        chk("rst_g", 32'(g), 32'd0);
        step(3'b111, 1'b1);
        chk("t1_g", 32'(g), 32'b001);
        chk("t1_id", 32'(gnt_id), 32'd0);

        // 3: timeout rotation under full load
        for (int i = 0; i < 3; i++) step(3'b111, 1'b1);
        step(3'b111, 1'b1);
        chk("t3_g1", 32'(g), 32'b010);
        chk("t3_pre1", 32'(preempt), 32'd1);
        for (int i = 0; i < 4; i++) step(3'b111, 1'b1);
        chk("t3_g2", 32'(g), 32'b100);
        for (int i = 0; i < 4; i++) step(3'b111, 1'b1);
        chk("t3_g0", 32'(g), 32'b001);
        chk("t3_pre0", 32'(preempt), 32'd1);

        // 2: zero-gap handover
        step(3'b000, 1'b0);
        step(3'b001, 1'b1);
        step(3'b110, 1'b1);
        chk("t2_g", 32'(g), 32'b010);
        chk("t2_pre", 32'(preempt), 32'd0);

        // 4: sole owner holds, then is pre-empted at saturation
        step(3'b000, 1'b0);
        for (int i = 0; i < 20; i++) step(3'b100, 1'b1);
        chk("t4_hold", 32'(g), 32'b100);
        step(3'b101, 1'b1);
        chk("t4_g", 32'(g), 32'b001);
        chk("t4_pre", 32'(preempt), 32'd1);

        // 5: wrap and release to idle
        step(3'b000, 1'b0);
        step(3'b100, 1'b1);
        step(3'b011, 1'b1);
        chk("t5_wrap", 32'(g), 32'b001);
        step(3'b010, 1'b1);
        chk("t5_g1", 32'(g), 32'b010);
        step(3'b000, 1'b1);
        chk("t5_idle", 32'(g), 32'd0);
        chk("t5_vld", 32'(gnt_valid), 32'd0);

        // 6: reset mid-grant
        step(3'b010, 1'b1);
        step(3'b010, 1'b0);
        chk("t6_rst", 32'(g), 32'd0);
        step(3'b110, 1'b1);
        chk("t6_g", 32'(g), 32'b010);

        // random traffic with occasional reset
        for (int i = 0; i < 300; i++)
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 49) != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
